// File: rtl/seu_rate_monitor_if.sv
// Rate result handshake between the SEU rate monitor (master) and its consumer (slave).
interface seu_rate_monitor_if #(
    parameter int RATEWIDTH = 16
);
    logic                 rateValid;
    logic                 rateReady;
    logic [RATEWIDTH-1:0] rate;

    modport master (output rateValid, output rate, input rateReady);
    modport slave  (input rateValid, input rate, output rateReady);
endinterface

// File: rtl/seu_rate_monitor.sv
// SEU rate monitor: turns a free-running upstream SEU counter into per-window
// increment counts, reports them over a valid/ready handshake, and raises an
// alarm when a window exceeds the threshold. Results closing while an earlier
// report is still unaccepted are dropped and flagged by a sticky overflow bit.
module seu_rate_monitor #(
    parameter int SEUCNTWIDTH  = 8,
    parameter int WINDOWCYCLES = 1024,
    parameter int RATEWIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEUCNTWIDTH-1:0] seuCount,
    input  logic                   seuCountRst,
    input  logic                   enable,
    input  logic [RATEWIDTH-1:0]   threshold,
    seu_rate_monitor_if.master     rif,
    output logic                   alarm,
    output logic                   overflow
);

    localparam int CW = $clog2(WINDOWCYCLES);
    localparam int SW = ((RATEWIDTH > SEUCNTWIDTH) ? RATEWIDTH : SEUCNTWIDTH) + 1;
    localparam logic [CW-1:0]        WIN_LAST = CW'(WINDOWCYCLES - 1);
    localparam logic [RATEWIDTH-1:0] RATE_MAX = '1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                 state_q, state_d;
    logic [SEUCNTWIDTH-1:0] seu_prev_q, seu_prev_d;
    logic [RATEWIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]          win_cnt_q, win_cnt_d;
    logic [RATEWIDTH-1:0]   rate_q, rate_d;
    logic                   rate_valid_q, rate_valid_d;
    logic                   alarm_q, alarm_d;
    logic                   overflow_q, overflow_d;

    logic [SEUCNTWIDTH-1:0] delta;
    logic [RATEWIDTH-1:0]   result;
    logic                   win_close;
    logic                   pending;

    // Saturating accumulate of an unsigned counter delta into the rate width.
    function automatic logic [RATEWIDTH-1:0] sat_add(input logic [RATEWIDTH-1:0] a,
                                                     input logic [SEUCNTWIDTH-1:0] b);
        logic [SW-1:0] sum;
        sum = SW'(a) + SW'(b);
        if (sum > SW'(RATE_MAX)) begin
            return RATE_MAX;
        end
        return sum[RATEWIDTH-1:0];
    endfunction

    // Modulo difference handles counter wrap; an upstream clear contributes nothing.
    assign delta     = seuCountRst ? '0 : SEUCNTWIDTH'(seuCount - seu_prev_q);
    assign result    = sat_add(acc_q, delta);
    // A window only closes while still enabled; dropping enable abandons it.
    assign win_close = (state_q == RUN) && enable && (win_cnt_q == WIN_LAST);
    assign pending   = rate_valid_q && !rif.rateReady;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enable gates every step, PRIME lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable ? PRIME : IDLE;
            PRIME:   state_d = enable ? RUN : IDLE;
            RUN:     state_d = enable ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window accumulation, result hand-off, alarm and overflow bookkeeping.
    always_comb begin
        seu_prev_d   = seuCountRst ? '0 : seuCount;
        acc_d        = '0;
        win_cnt_d    = '0;
        rate_d       = rate_q;
        rate_valid_d = rate_valid_q;
        alarm_d      = alarm_q;
        overflow_d   = overflow_q;

        if ((state_q == RUN) && enable && !win_close) begin
            acc_d     = result;
            win_cnt_d = win_cnt_q + 1'b1;
        end

        if (rate_valid_q && rif.rateReady) begin
            rate_valid_d = 1'b0;
        end

        if (win_close) begin
            alarm_d = (result > threshold);
            if (pending) begin
                overflow_d = 1'b1;
            end else begin
                rate_d       = result;
                rate_valid_d = 1'b1;
            end
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seu_prev_q   <= '0;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            alarm_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            seu_prev_q   <= seu_prev_d;
            acc_q        <= acc_d;
            win_cnt_q    <= win_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            alarm_q      <= alarm_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rif.rate      = rate_q;
    assign rif.rateValid = rate_valid_q;
    assign alarm         = alarm_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_seu_rate_monitor.sv
// Directed testbench for seu_rate_monitor with an 8-cycle window.
module tb_seu_rate_monitor;

    localparam int SEUCNTWIDTH  = 8;
    localparam int WINDOWCYCLES = 8;
    localparam int RATEWIDTH    = 16;

    logic                   clk;
    logic                   rst;
    logic [SEUCNTWIDTH-1:0] seuCount;
    logic                   seuCountRst;
    logic                   enable;
    logic [RATEWIDTH-1:0]   threshold;
    logic                   alarm;
    logic                   overflow;
    logic [SEUCNTWIDTH-1:0] sv;

    int checks;
    int failures;

    seu_rate_monitor_if #(.RATEWIDTH(RATEWIDTH)) rif ();

    seu_rate_monitor #(
        .SEUCNTWIDTH (SEUCNTWIDTH),
        .WINDOWCYCLES(WINDOWCYCLES),
        .RATEWIDTH   (RATEWIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seuCount   (seuCount),
        .seuCountRst(seuCountRst),
        .enable     (enable),
        .threshold  (threshold),
        .rif        (rif.master),
        .alarm      (alarm),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle with seuCount = v during it; returns 1 time unit after the edge.
    task automatic cyc(input logic [SEUCNTWIDTH-1:0] v);
        seuCount = v;
        sv = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n, input int inc);
        for (int i = 0; i < n; i++) begin
            cyc(SEUCNTWIDTH'(sv + SEUCNTWIDTH'(inc)));
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        enable = 1'b0;
        seuCountRst = 1'b0;
        rif.rateReady = 1'b0;
        seuCount = '0;
        sv = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (rif.rateValid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", rif.rateValid);
        end
        checks++;
        if (rif.rate !== 16'd0) begin
            failures++; $display("FAIL reset_rate got=%0d exp=0", rif.rate);
        end
        checks++;
        if (alarm !== 1'b0) begin
            failures++; $display("FAIL reset_alarm got=%0b exp=0", alarm);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        threshold = 16'd7;
        enable = 1'b1;
        sv = 8'd4;
        run_cycles(2, 1);          // IDLE (5), PRIME (6)
        run_cycles(7, 1);          // RUN cycles 0..6
        checks++;
        if (rif.rateValid !== 1'b0) begin
            failures++; $display("FAIL basic_valid_early got=%0b exp=0", rif.rateValid);
        end
        run_cycles(1, 1);          // close cycle
        checks++;
        if (rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL basic_valid got=%0b exp=1", rif.rateValid);
        end
        checks++;
        if (rif.rate !== 16'd8) begin
            failures++; $display("FAIL basic_rate got=%0d exp=8", rif.rate);
        end
        checks++;
        if (alarm !== 1'b1) begin
            failures++; $display("FAIL basic_alarm_th7 got=%0b exp=1", alarm);
        end
        threshold = 16'd8;
        rif.rateReady = 1'b1;
        run_cycles(1, 1);
        checks++;
        if (rif.rateValid !== 1'b0) begin
            failures++; $display("FAIL basic_valid_drop got=%0b exp=0", rif.rateValid);
        end
        rif.rateReady = 1'b0;
        run_cycles(7, 1);
        checks++;
        if (rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL basic_valid2 got=%0b exp=1", rif.rateValid);
        end
        checks++;
        if (rif.rate !== 16'd8) begin
            failures++; $display("FAIL basic_rate2 got=%0d exp=8", rif.rate);
        end
        checks++;
        if (alarm !== 1'b0) begin
            failures++; $display("FAIL basic_alarm_th8 got=%0b exp=0", alarm);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        threshold = 16'd1000;
        rif.rateReady = 1'b1;
        enable = 1'b1;
        cyc(8'd240);               // IDLE
        cyc(8'd241);               // PRIME
        cyc(8'd242); cyc(8'd243); cyc(8'd250); cyc(8'd3);
        cyc(8'd4);   cyc(8'd4);   cyc(8'd5);   cyc(8'd6);
        checks++;
        if (rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL wrap_valid got=%0b exp=1", rif.rateValid);
        end
        checks++;
        if (rif.rate !== 16'd21) begin
            failures++; $display("FAIL wrap_rate got=%0d exp=21", rif.rate);
        end
    endtask

    task automatic test_seu_clear();
        apply_reset();
        threshold = 16'd1000;
        rif.rateReady = 1'b1;
        enable = 1'b1;
        cyc(8'd190);               // IDLE
        cyc(8'd195);               // PRIME
        cyc(8'd198); cyc(8'd200);
        seuCountRst = 1'b1;
        cyc(8'd0);
        seuCountRst = 1'b0;
        cyc(8'd1); cyc(8'd2); cyc(8'd3); cyc(8'd5); cyc(8'd6);
        checks++;
        if (rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL clear_valid got=%0b exp=1", rif.rateValid);
        end
        checks++;
        if (rif.rate !== 16'd11) begin
            failures++; $display("FAIL clear_rate got=%0d exp=11", rif.rate);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        threshold = 16'd10;
        enable = 1'b1;
        run_cycles(2, 1);
        run_cycles(8, 1);
        checks++;
        if (rif.rate !== 16'd8 || rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL ovf_first got rate=%0d valid=%0b exp rate=8 valid=1", rif.rate, rif.rateValid);
        end
        checks++;
        if (alarm !== 1'b0) begin
            failures++; $display("FAIL ovf_alarm1 got=%0b exp=0", alarm);
        end
        run_cycles(3, 2);
        checks++;
        if (rif.rate !== 16'd8 || rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL ovf_stable got rate=%0d valid=%0b exp rate=8 valid=1", rif.rate, rif.rateValid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_early got=%0b exp=0", overflow);
        end
        run_cycles(5, 2);
        checks++;
        if (rif.rate !== 16'd8 || rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL ovf_held got rate=%0d valid=%0b exp rate=8 valid=1", rif.rate, rif.rateValid);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_set got=%0b exp=1", overflow);
        end
        checks++;
        if (alarm !== 1'b1) begin
            failures++; $display("FAIL ovf_alarm2 got=%0b exp=1", alarm);
        end
        rif.rateReady = 1'b1;
        run_cycles(1, 0);
        checks++;
        if (rif.rateValid !== 1'b0) begin
            failures++; $display("FAIL ovf_accept got=%0b exp=0", rif.rateValid);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        threshold = 16'd100;
        enable = 1'b1;
        run_cycles(2, 1);
        run_cycles(8, 1);
        checks++;
        if (rif.rate !== 16'd8 || rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL b2b_first got rate=%0d valid=%0b exp rate=8 valid=1", rif.rate, rif.rateValid);
        end
        run_cycles(7, 3);
        rif.rateReady = 1'b1;
        run_cycles(1, 3);
        checks++;
        if (rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL b2b_valid got=%0b exp=1", rif.rateValid);
        end
        checks++;
        if (rif.rate !== 16'd24) begin
            failures++; $display("FAIL b2b_rate got=%0d exp=24", rif.rate);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL b2b_overflow got=%0b exp=0", overflow);
        end
        run_cycles(1, 0);
        checks++;
        if (rif.rateValid !== 1'b0) begin
            failures++; $display("FAIL b2b_drop got=%0b exp=0", rif.rateValid);
        end
    endtask

    task automatic test_enable_and_reset();
        apply_reset();
        threshold = 16'd7;
        enable = 1'b1;
        run_cycles(2, 5);
        run_cycles(4, 5);          // partial window: cycles 0..3
        enable = 1'b0;
        run_cycles(1, 5);
        run_cycles(3, 5);
        checks++;
        if (rif.rateValid !== 1'b0) begin
            failures++; $display("FAIL en_no_report got=%0b exp=0", rif.rateValid);
        end
        enable = 1'b1;
        run_cycles(2, 5);          // IDLE, PRIME: not counted
        run_cycles(8, 1);
        checks++;
        if (rif.rate !== 16'd8 || rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL en_rate got rate=%0d valid=%0b exp rate=8 valid=1", rif.rate, rif.rateValid);
        end
        checks++;
        if (alarm !== 1'b1) begin
            failures++; $display("FAIL en_alarm got=%0b exp=1", alarm);
        end
        run_cycles(3, 1);
        rst = 1'b1;
        #2;
        checks++;
        if (rif.rateValid !== 1'b0 || rif.rate !== 16'd0) begin
            failures++; $display("FAIL rst_async_rate got rate=%0d valid=%0b exp rate=0 valid=0", rif.rate, rif.rateValid);
        end
        checks++;
        if (alarm !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL rst_async_flags got alarm=%0b overflow=%0b exp 0 0", alarm, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        threshold = 16'd15;
        run_cycles(2, 5);
        run_cycles(7, 2);
        checks++;
        if (rif.rateValid !== 1'b0) begin
            failures++; $display("FAIL rst_no_early got=%0b exp=0", rif.rateValid);
        end
        run_cycles(1, 2);
        checks++;
        if (rif.rate !== 16'd16 || rif.rateValid !== 1'b1) begin
            failures++; $display("FAIL rst_rate got rate=%0d valid=%0b exp rate=16 valid=1", rif.rate, rif.rateValid);
        end
        checks++;
        if (alarm !== 1'b1) begin
            failures++; $display("FAIL rst_alarm got=%0b exp=1", alarm);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        enable = 1'b0;
        seuCountRst = 1'b0;
        seuCount = '0;
        threshold = '0;
        rif.rateReady = 1'b0;
        sv = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_seu_clear();
        test_overflow();
        test_back_to_back();
        test_enable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
